axis_checking_sink: RTL and testbench

Parametrised AXI4-Stream sink for block-level and system benches. It is the successor of the plain data sink. Adds:
- programmable backpressure patterns on TREADY;
- an incrementing-data checker;
- packet/beat accounting;
- AXI stability (protocol) checking.

It sits at the end of a stream datapath as the terminating slave and exposes status counters and sticky error flags to the bench or to a CSR block.

---
 rtl/axis_checking_sink.sv | 226 ++++++++++++++++++++++
 tb/tb_axis_checking_sink.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_checking_sink.sv
// ---------------------------------------------------------------------------
// axis_checking_sink
//
// Terminating AXI4-Stream slave for block and system benches. It drives a
// registered TREADY according to a programmable backpressure pattern, checks
// that accepted data increments by one per beat, counts beats and packets,
// records the length of the last packet, and flags stream-stability
// violations on the master side. All error flags are sticky until ARESET or
// CLEAR.
//
// Optional feature: define AXIS_SINK_ERR_CAPTURE_EN to add ERR_EXP_DATA,
// ERR_GOT_DATA and ERR_BEAT, which freeze the expected data, received data
// and BEAT_COUNT at the first data mismatch.
//
// Ports
//   ACLK            clock
//   ARESET          synchronous active-high reset
//   S_AXIS_TVALID   stream valid
//   S_AXIS_TREADY   stream ready (registered)
//   S_AXIS_TDATA    stream data
//   S_AXIS_TLAST    end-of-packet marker
//   CFG_READY_MODE  0 always, 1 never, 2 alternate, 3 LFSR random
//   CFG_SEED        LFSR seed (0 selects 16'hACE1), loaded on reset/CLEAR
//   CFG_CHECK_EN    enables DATA_ERR reporting
//   CLEAR           one-cycle clear of counters, flags, checker and LFSR
//   BEAT_COUNT      accepted beats (wraps)
//   PKT_COUNT       accepted TLAST beats (wraps)
//   LAST_PKT_LEN    beats in the most recently completed packet
//   DATA_ERR        sticky data mismatch
//   LEN_ERR         sticky packet longer than MAX_PKT_LEN
//   PROTO_ERR       sticky TVALID drop or TDATA/TLAST change while stalled
// ---------------------------------------------------------------------------
module axis_checking_sink #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 64,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic [1:0]            CFG_READY_MODE,
  input  logic [15:0]           CFG_SEED,
  input  logic                  CFG_CHECK_EN,
  input  logic                  CLEAR,
  output logic [31:0]           BEAT_COUNT,
  output logic [31:0]           PKT_COUNT,
  output logic [LEN_WIDTH-1:0]  LAST_PKT_LEN,
  output logic                  DATA_ERR,
  output logic                  LEN_ERR,
  output logic                  PROTO_ERR
`ifdef AXIS_SINK_ERR_CAPTURE_EN
  ,
  output logic [DATA_WIDTH-1:0] ERR_EXP_DATA,
  output logic [DATA_WIDTH-1:0] ERR_GOT_DATA,
  output logic [31:0]           ERR_BEAT
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  localparam logic [15:0]           DEFAULT_SEED = 16'hACE1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE     = DATA_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]    LEN_ONE_W    = (LEN_WIDTH + 1)'(1);
  localparam logic [LEN_WIDTH:0]    MAX_LEN_W    = (LEN_WIDTH + 1)'(MAX_PKT_LEN);

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   pkt_len_q, pkt_len_d;
  logic [15:0]            lfsr_q;
  logic                   seeded_q;
  logic [DATA_WIDTH-1:0]  exp_q;
  logic                   stall_q;
  logic [DATA_WIDTH-1:0]  held_data_q;
  logic                   held_last_q;

  logic                   xfer;
  logic [15:0]            seed_eff;
  logic [15:0]            lfsr_next;
  logic                   ready_next;
  logic [LEN_WIDTH:0]     beat_num_w;
  logic [LEN_WIDTH-1:0]   beat_num;
  logic                   pkt_done;
  logic                   len_viol;
  logic                   data_mismatch;
  logic                   proto_viol;

  assign xfer     = S_AXIS_TVALID && S_AXIS_TREADY;
  assign seed_eff = (CFG_SEED == 16'h0000) ? DEFAULT_SEED : CFG_SEED;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Next TREADY never looks at TVALID, so the pattern is source-independent.
  always_comb begin
    ready_next = 1'b1;
    case (CFG_READY_MODE)
      2'd0:    ready_next = 1'b1;
      2'd1:    ready_next = 1'b0;
      2'd2:    ready_next = ~S_AXIS_TREADY;
      default: ready_next = lfsr_q[0];
    endcase
  end

  // Length of the current beat within its packet; the extra bit keeps the
  // unsaturated value so the length check sees the true count.
  assign beat_num_w = (state_q == IDLE) ? LEN_ONE_W : ({1'b0, pkt_len_q} + LEN_ONE_W);
  assign beat_num   = beat_num_w[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : beat_num_w[LEN_WIDTH-1:0];

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pkt_len_d = pkt_len_q;
    pkt_done  = 1'b0;
    len_viol  = 1'b0;
    if (xfer) begin
      len_viol = (beat_num_w > MAX_LEN_W);
      if (S_AXIS_TLAST) begin
        state_d   = IDLE;
        pkt_len_d = '0;
        pkt_done  = 1'b1;
      end else begin
        state_d   = IN_PKT;
        pkt_len_d = beat_num;
      end
    end
  end

  assign data_mismatch = seeded_q && (S_AXIS_TDATA != exp_q);

  // A beat offered but not taken last cycle must be presented unchanged.
  assign proto_viol = stall_q &&
                      (!S_AXIS_TVALID ||
                       (S_AXIS_TDATA != held_data_q) ||
                       (S_AXIS_TLAST != held_last_q));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      pkt_len_q     <= '0;
      lfsr_q        <= seed_eff;
      S_AXIS_TREADY <= 1'b0;
      seeded_q      <= 1'b0;
      exp_q         <= '0;
      stall_q       <= 1'b0;
      held_data_q   <= '0;
      held_last_q   <= 1'b0;
      BEAT_COUNT    <= '0;
      PKT_COUNT     <= '0;
      LAST_PKT_LEN  <= '0;
      DATA_ERR      <= 1'b0;
      LEN_ERR       <= 1'b0;
      PROTO_ERR     <= 1'b0;
`ifdef AXIS_SINK_ERR_CAPTURE_EN
      ERR_EXP_DATA  <= '0;
      ERR_GOT_DATA  <= '0;
      ERR_BEAT      <= '0;
`endif
    end else if (CLEAR) begin
      // Same as reset, except the ready pattern keeps running; a beat
      // accepted on this edge is dropped.
      state_q       <= IDLE;
      pkt_len_q     <= '0;
      lfsr_q        <= seed_eff;
      S_AXIS_TREADY <= ready_next;
      seeded_q      <= 1'b0;
      exp_q         <= '0;
      stall_q       <= 1'b0;
      held_data_q   <= '0;
      held_last_q   <= 1'b0;
      BEAT_COUNT    <= '0;
      PKT_COUNT     <= '0;
      LAST_PKT_LEN  <= '0;
      DATA_ERR      <= 1'b0;
      LEN_ERR       <= 1'b0;
      PROTO_ERR     <= 1'b0;
`ifdef AXIS_SINK_ERR_CAPTURE_EN
      ERR_EXP_DATA  <= '0;
      ERR_GOT_DATA  <= '0;
      ERR_BEAT      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pkt_len_q     <= pkt_len_d;
      lfsr_q        <= lfsr_next;
      S_AXIS_TREADY <= ready_next;

      stall_q     <= S_AXIS_TVALID && !S_AXIS_TREADY;
      held_data_q <= S_AXIS_TDATA;
      held_last_q <= S_AXIS_TLAST;
      if (proto_viol) PROTO_ERR <= 1'b1;

      if (xfer) begin
        BEAT_COUNT <= BEAT_COUNT + 32'd1;
        if (pkt_done) begin
          PKT_COUNT    <= PKT_COUNT + 32'd1;
          LAST_PKT_LEN <= beat_num;
        end
        if (len_viol) LEN_ERR <= 1'b1;

        // Expected always follows the received beat, so a mismatch
        // re-synchronises the checker to the new sequence.
        seeded_q <= 1'b1;
        exp_q    <= S_AXIS_TDATA + DATA_ONE;
        if (data_mismatch && CFG_CHECK_EN) begin
          DATA_ERR <= 1'b1;
`ifdef AXIS_SINK_ERR_CAPTURE_EN
          if (!DATA_ERR) begin
            ERR_EXP_DATA <= exp_q;
            ERR_GOT_DATA <= S_AXIS_TDATA;
            ERR_BEAT     <= BEAT_COUNT;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_checking_sink.sv
// ---------------------------------------------------------------------------
// tb_axis_checking_sink
//
// Self-checking bench for axis_checking_sink (DATA_WIDTH 32, MAX_PKT_LEN 64,
// LEN_WIDTH 16). A transaction-level reference model tracks the expected
// ready pattern, counters and flags; every output is compared after every
// clock edge, and directed scenarios add explicit expected constants.
// ---------------------------------------------------------------------------
module tb_axis_checking_sink;

  localparam int DW      = 32;
  localparam int MAX_LEN = 64;
  localparam int LW      = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          S_AXIS_TVALID;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] S_AXIS_TDATA;
  logic          S_AXIS_TLAST;
  logic [1:0]    CFG_READY_MODE;
  logic [15:0]   CFG_SEED;
  logic          CFG_CHECK_EN;
  logic          CLEAR;
  logic [31:0]   BEAT_COUNT;
  logic [31:0]   PKT_COUNT;
  logic [LW-1:0] LAST_PKT_LEN;
  logic          DATA_ERR;
  logic          LEN_ERR;
  logic          PROTO_ERR;
`ifdef AXIS_SINK_ERR_CAPTURE_EN
  logic [DW-1:0] ERR_EXP_DATA;
  logic [DW-1:0] ERR_GOT_DATA;
  logic [31:0]   ERR_BEAT;
`endif

  axis_checking_sink #(
    .DATA_WIDTH (DW),
    .MAX_PKT_LEN(MAX_LEN),
    .LEN_WIDTH  (LW)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .CFG_READY_MODE(CFG_READY_MODE),
    .CFG_SEED      (CFG_SEED),
    .CFG_CHECK_EN  (CFG_CHECK_EN),
    .CLEAR         (CLEAR),
    .BEAT_COUNT    (BEAT_COUNT),
    .PKT_COUNT     (PKT_COUNT),
    .LAST_PKT_LEN  (LAST_PKT_LEN),
    .DATA_ERR      (DATA_ERR),
    .LEN_ERR       (LEN_ERR),
    .PROTO_ERR     (PROTO_ERR)
`ifdef AXIS_SINK_ERR_CAPTURE_EN
    ,
    .ERR_EXP_DATA  (ERR_EXP_DATA),
    .ERR_GOT_DATA  (ERR_GOT_DATA),
    .ERR_BEAT      (ERR_BEAT)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ready;
  logic [15:0] m_lfsr;
  int unsigned m_beats, m_pkts;
  int          m_cur;       // beats so far in the open packet, 0 when idle
  int          m_last_len;
  bit          m_derr, m_lerr, m_perr;
  bit          m_seeded;
  logic [31:0] m_exp;
  bit          m_stall;
  logic [31:0] m_pdata;
  bit          m_plast;
  logic [31:0] m_cap_exp, m_cap_got, m_cap_beat;
  bit          last_xfer;

  function automatic logic [15:0] eff_seed();
    return (CFG_SEED == 16'h0) ? 16'hACE1 : CFG_SEED;
  endfunction

  // Right-shifting Fibonacci LFSR with taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic model_clear();
    m_beats = 0; m_pkts = 0; m_cur = 0; m_last_len = 0;
    m_derr = 0; m_lerr = 0; m_perr = 0;
    m_seeded = 0; m_exp = '0; m_stall = 0;
    m_cap_exp = '0; m_cap_got = '0; m_cap_beat = '0;
    m_lfsr = eff_seed();
  endtask

  task automatic model_edge();
    bit rdy_old;
    bit nt;
    int n;
    rdy_old   = m_ready;
    last_xfer = 0;
    if (ARESET) begin
      model_clear();
      m_ready = 0;
      return;
    end
    case (CFG_READY_MODE)
      2'd0:    nt = 1;
      2'd1:    nt = 0;
      2'd2:    nt = !rdy_old;
      default: nt = m_lfsr[0];
    endcase
    if (CLEAR) begin
      model_clear();
    end else begin
      m_lfsr = lfsr_step(m_lfsr);
      if (m_stall && (!S_AXIS_TVALID || S_AXIS_TDATA !== m_pdata || S_AXIS_TLAST !== m_plast))
        m_perr = 1;
      m_stall = S_AXIS_TVALID && !rdy_old;
      m_pdata = S_AXIS_TDATA;
      m_plast = S_AXIS_TLAST;
      if (S_AXIS_TVALID && rdy_old) begin
        last_xfer = 1;
        n = m_cur + 1;
        if (n > MAX_LEN) m_lerr = 1;
        if (n > 65535) n = 65535;
        if (m_seeded && S_AXIS_TDATA !== m_exp && CFG_CHECK_EN) begin
          if (!m_derr) begin
            m_cap_exp  = m_exp;
            m_cap_got  = S_AXIS_TDATA;
            m_cap_beat = m_beats;
          end
          m_derr = 1;
        end
        m_seeded = 1;
        m_exp    = S_AXIS_TDATA + 32'd1;
        m_beats++;
        if (S_AXIS_TLAST) begin
          m_pkts++;
          m_last_len = n;
          m_cur = 0;
        end else begin
          m_cur = n;
        end
      end
    end
    m_ready = nt;
  endtask

  // One clock: update the model at the edge, compare every output 1 ns later.
  task automatic tick();
    @(posedge ACLK);
    model_edge();
    cyc++;
    #1;
    check("tready",   S_AXIS_TREADY, m_ready);
    check("beats",    BEAT_COUNT,    m_beats);
    check("pkts",     PKT_COUNT,     m_pkts);
    check("last_len", LAST_PKT_LEN,  m_last_len);
    check("data_err", DATA_ERR,      m_derr);
    check("len_err",  LEN_ERR,       m_lerr);
    check("proto_err",PROTO_ERR,     m_perr);
`ifdef AXIS_SINK_ERR_CAPTURE_EN
    check("cap_exp",  ERR_EXP_DATA,  m_cap_exp);
    check("cap_got",  ERR_GOT_DATA,  m_cap_got);
    check("cap_beat", ERR_BEAT,      m_cap_beat);
`endif
  endtask

  task automatic do_reset();
    ARESET = 1;
    tick();
    tick();
    ARESET = 0;
  endtask

  // Hold a beat until it is accepted; optional random CLEAR pulses.
  task automatic send_beat(input logic [31:0] d, input bit l, input bit rnd_clear);
    bit done;
    done = 0;
    S_AXIS_TVALID = 1;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      CLEAR = rnd_clear && ($urandom_range(0, 299) == 0);
      tick();
      CLEAR = 0;
      if (last_xfer) done = 1;
    end
    check("xfer_timeout", done, 1);
  endtask

  task automatic idle(input int n);
    S_AXIS_TVALID = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int start;
  logic [31:0] d;

  initial begin
    ARESET = 1; S_AXIS_TVALID = 0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 0;
    CFG_READY_MODE = 2'd0; CFG_SEED = 16'h0001; CFG_CHECK_EN = 1; CLEAR = 0;
    m_ready = 0;
    model_clear();

    // Reset state
    do_reset();
    check("rst_tready", S_AXIS_TREADY, 0);
    check("rst_beats",  BEAT_COUNT, 0);
    check("rst_flags",  {DATA_ERR, LEN_ERR, PROTO_ERR}, 3'b000);

    // Mode 0: 32 beats 0..31
    for (int i = 0; i < 32; i++) send_beat(i, i == 31, 0);
    idle(2);
    check("m0_beats", BEAT_COUNT, 32);
    check("m0_pkts",  PKT_COUNT, 1);
    check("m0_len",   LAST_PKT_LEN, 32);
    check("m0_flags", {DATA_ERR, LEN_ERR, PROTO_ERR}, 3'b000);

    // Mode 2: alternating ready, source holds while stalled
    CFG_READY_MODE = 2'd2;
    do_reset();
    for (int i = 0; i < 32; i++) send_beat(i, i == 31, 0);
    idle(2);
    check("m2_beats", BEAT_COUNT, 32);
    check("m2_pkts",  PKT_COUNT, 1);
    check("m2_proto", PROTO_ERR, 0);

    // Mode 3: LFSR ready pattern, seed 1 then seed 0 (0xACE1)
    CFG_READY_MODE = 2'd3;
    for (int s = 0; s < 2; s++) begin
      CFG_SEED = (s == 0) ? 16'h0001 : 16'h0000;
      do_reset();
      start = cyc;
      d = 0;
      while (cyc - start < 1000) begin
        send_beat(d, 0, 0);
        d++;
      end
      check("m3_proto", PROTO_ERR, 0);
      check("m3_data",  DATA_ERR, 0);
      idle(1);
    end

    // Data 5,6,8,9
    CFG_READY_MODE = 2'd0;
    do_reset();
    send_beat(5, 0, 0);
    send_beat(6, 0, 0);
    check("derr_before", DATA_ERR, 0);
    send_beat(8, 0, 0);
    check("derr_after8", DATA_ERR, 1);
    send_beat(9, 1, 0);
    idle(1);
    check("derr_sticky", DATA_ERR, 1);
`ifdef AXIS_SINK_ERR_CAPTURE_EN
    check("cap_exp7", ERR_EXP_DATA, 7);
    check("cap_got8", ERR_GOT_DATA, 8);
    check("cap_beat2", ERR_BEAT, 2);
`endif

    // 70-beat packet, then CLEAR
    do_reset();
    for (int i = 0; i < 70; i++) send_beat(i, i == 69, 0);
    idle(1);
    check("len_err",  LEN_ERR, 1);
    check("len_70",   LAST_PKT_LEN, 70);
    check("len_pkts", PKT_COUNT, 1);
    CLEAR = 1;
    tick();
    CLEAR = 0;
    check("clr_beats", BEAT_COUNT, 0);
    check("clr_pkts",  PKT_COUNT, 0);
    check("clr_len",   LAST_PKT_LEN, 0);
    check("clr_flags", {DATA_ERR, LEN_ERR, PROTO_ERR}, 3'b000);
    check("clr_ready", S_AXIS_TREADY, 1);

    // Mode 1: data changes while stalled
    CFG_READY_MODE = 2'd1;
    do_reset();
    S_AXIS_TVALID = 1; S_AXIS_TDATA = 32'hA; S_AXIS_TLAST = 0;
    tick(); tick(); tick();
    check("m1_noerr", PROTO_ERR, 0);
    S_AXIS_TDATA = 32'hB;
    tick();
    check("m1_proto", PROTO_ERR, 1);
    check("m1_beats", BEAT_COUNT, 0);

    // Reset mid-packet in mode 0
    CFG_READY_MODE = 2'd0;
    idle(2);
    for (int i = 0; i < 3; i++) send_beat(i, 0, 0);
    do_reset();
    check("mid_beats", BEAT_COUNT, 0);
    check("mid_pkts",  PKT_COUNT, 0);
    for (int i = 0; i < 4; i++) send_beat(100 + i, i == 3, 0);
    idle(1);
    check("mid_len4", LAST_PKT_LEN, 4);
    check("mid_pkt1", PKT_COUNT, 1);

    // Randomized traffic
    CFG_SEED = 16'(($urandom & 32'hFFFF));
    do_reset();
    d = $urandom;
    for (int p = 0; p < 60; p++) begin
      int len;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       CFG_READY_MODE = 2'd0;
          1:       CFG_READY_MODE = 2'd2;
          default: CFG_READY_MODE = 2'd3;
        endcase
      end
      CFG_CHECK_EN = ($urandom_range(0, 4) != 0);
      len = $urandom_range(1, 80);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 24) == 0) d = d + $urandom_range(2, 9);
        send_beat(d, b == len - 1, 1);
        d++;
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
